load_unit: RTL and testbench

Sequential load path of the data-memory interface, the read-side counterpart to the store merge logic. On `start` it decodes a load instruction, requests a doubleword from data memory, and waits for the memory's valid response. It then extracts the low byte, half, word or doubleword and sign- or zero-extends it to 64 bits for register writeback. A timeout and an illegal-encoding flag report failures to the pipeline control.

---
 rtl/load_unit.sv | 149 ++++++++++++++
 tb/tb_load_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: sequential load path of the data-memory interface.
//
// On an accepted start the instruction is decoded. A legal load issues a
// doubleword read and waits for mem_valid. The low byte/half/word/doubleword
// of the response is then sign- or zero-extended to 64 bits. A read with no
// response within TIMEOUT cycles is aborted with err. An illegal encoding
// completes immediately with err and issues no memory request.
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous active-high reset
//   start     in   1   single-cycle request, sampled only in IDLE
//   Inst      in  32   instruction (opcode [6:0], funct3 [14:12])
//   mem_valid in   1   memory response valid, MemIn valid in the same cycle
//   MemIn     in  64   doubleword from data memory, addressed data in low lanes
//   mem_rd    out  1   read request, high for the whole of BUSY
//   busy      out  1   high in BUSY and DONE
//   done      out  1   one-cycle completion pulse
//   err       out  1   failure flag, coincident with done
//   Out       out 64   extended load result, held between accesses
module load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Inst,
  input  logic        mem_valid,
  input  logic [63:0] MemIn,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  // Counter value seen in the last BUSY cycle before the access is aborted.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        mem_rd_reg, mem_rd_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [63:0] out_reg, out_next;

  // Only the opcode and funct3 fields of the instruction are relevant here.
  logic unused_inst;
  assign unused_inst = ^{Inst[31:15], Inst[11:7]};

  function automatic logic [63:0] extract(input logic [2:0] f3, input logic [63:0] d);
    logic [63:0] r;
    case (f3)
      3'b000:  r = {{56{d[7]}},  d[7:0]};
      3'b001:  r = {{48{d[15]}}, d[15:0]};
      3'b010:  r = {{32{d[31]}}, d[31:0]};
      3'b011:  r = d;
      3'b100:  r = {56'h0, d[7:0]};
      3'b101:  r = {48'h0, d[15:0]};
      3'b110:  r = {32'h0, d[31:0]};
      default: r = d;  // unreachable: 111 never reaches BUSY
    endcase
    return r;
  endfunction

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    funct3_next = funct3_reg;
    out_next    = out_reg;
    err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          funct3_next = Inst[14:12];
          if (Inst[6:0] == OPC_LOAD && Inst[14:12] != 3'b111) begin
            state_next = BUSY;
            count_next = 8'd0;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
          end
        end
      end
      BUSY: begin
        // A response in the final BUSY cycle still counts as success.
        if (mem_valid) begin
          out_next   = extract(funct3_reg, MemIn);
          state_next = DONE;
        end else if (count_reg == LAST_COUNT) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered versions of what the next state implies.
    mem_rd_next = (state_next == BUSY);
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= 8'd0;
      funct3_reg <= 3'b000;
      mem_rd_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      out_reg    <= 64'h0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      funct3_reg <= funct3_next;
      mem_rd_reg <= mem_rd_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      out_reg    <= out_next;
    end
  end

  assign mem_rd = mem_rd_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign Out    = out_reg;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] Inst;
  logic        mem_valid;
  logic [63:0] MemIn;
  logic        mem_rd;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] Out;

  int n_checks;
  int n_fail;

  load_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .Inst(Inst),
    .mem_valid(mem_valid), .MemIn(MemIn), .mem_rd(mem_rd),
    .busy(busy), .done(done), .err(err), .Out(Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'h0, op};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and run until done (or the cycle budget expires).
  // valid_at: BUSY cycle number (1-based) carrying mem_valid; 0 means never.
  // done_cyc: cycle after the accepting edge where done is seen (-1 on expiry).
  // Returns positioned in the cycle after done.
  task automatic run_load(input logic [31:0] inst, input int valid_at, input logic [63:0] data,
                          output int done_cyc, output logic err_o, output logic [63:0] out_o,
                          output int rd_cyc);
    done_cyc = -1;
    err_o    = 1'b0;
    out_o    = 64'h0;
    rd_cyc   = 0;
    start = 1'b1;
    Inst  = inst;
    step();
    start = 1'b0;
    Inst  = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        err_o    = err;
        out_o    = Out;
        break;
      end
      if (mem_rd) rd_cyc++;
      if (valid_at > 0 && c == valid_at) begin
        mem_valid = 1'b1;
        MemIn     = data;
      end
      step();
      mem_valid = 1'b0;
      MemIn     = 64'h0;
    end
    $display("load inst=%08h done_cyc=%0d err=%0b out=%016h rd_cycles=%0d",
             inst, done_cyc, err_o, out_o, rd_cyc);
    if (done_cyc >= 0) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({mem_rd, busy, done, err} !== 4'b0000 || Out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: mem_rd/busy/done/err=%b Out=%016h required 0000 / 0", {mem_rd, busy, done, err}, Out);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if ({mem_rd, busy, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: flags=%b required 0000", {mem_rd, busy, done, err});
    end
  endtask

  task automatic test_lb();
    int dc, rc;
    logic e;
    logic [63:0] o;
    run_load(mk_inst(3'b000, 7'b0000011), 1, 64'h1234_5678_9ABC_DE80, dc, e, o, rc);
    n_checks++;
    if (o !== 64'hFFFF_FFFF_FFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_out: got %016h required FFFFFFFFFFFFFF80", o);
    end
    n_checks++;
    if (dc !== 2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_timing: done_cyc=%0d err=%0b required 2 / 0", dc, e);
    end
  endtask

  task automatic test_back_to_back();
    int dc, rc;
    logic e;
    logic [63:0] o;
    run_load(mk_inst(3'b101, 7'b0000011), 1, 64'h0000_0000_0000_8001, dc, e, o, rc);
    n_checks++;
    if (o !== 64'h0000_0000_0000_8001 || dc !== 2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu: out=%016h done_cyc=%0d err=%0b required 0000000000008001 / 2 / 0", o, dc, e);
    end
    // The cycle between the two done pulses must be IDLE.
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: done=%0b busy=%0b required 0 / 0", done, busy);
    end
    run_load(mk_inst(3'b001, 7'b0000011), 1, 64'h0000_0000_0000_8001, dc, e, o, rc);
    n_checks++;
    if (o !== 64'hFFFF_FFFF_FFFF_8001 || dc !== 2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lh: out=%016h done_cyc=%0d err=%0b required FFFFFFFFFFFF8001 / 2 / 0", o, dc, e);
    end
  endtask

  task automatic test_word_waits();
    logic [2:0]  f3s [3];
    logic [63:0] exp [3];
    int dc, rc;
    logic e;
    logic [63:0] o;
    f3s[0] = 3'b010; exp[0] = 64'hFFFF_FFFF_8765_4321;
    f3s[1] = 3'b110; exp[1] = 64'h0000_0000_8765_4321;
    f3s[2] = 3'b011; exp[2] = 64'hDEAD_BEEF_8765_4321;
    for (int i = 0; i < 3; i++) begin
      // mem_valid in the 4th BUSY cycle, which is also the timeout cycle.
      run_load(mk_inst(f3s[i], 7'b0000011), 4, 64'hDEAD_BEEF_8765_4321, dc, e, o, rc);
      n_checks++;
      if (o !== exp[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_load_f3_%0d: out=%016h err=%0b required %016h / 0", f3s[i], o, e, exp[i]);
      end
      n_checks++;
      if (rc !== 4 || dc !== 5) begin
        n_fail++;
        $display("FAIL wait_timing_f3_%0d: rd_cycles=%0d done_cyc=%0d required 4 / 5", f3s[i], rc, dc);
      end
    end
  endtask

  task automatic test_timeout();
    int dc, rc;
    logic e;
    logic [63:0] o;
    run_load(mk_inst(3'b000, 7'b0000011), 0, 64'h0, dc, e, o, rc);
    n_checks++;
    if (dc !== 5 || e !== 1'b1 || rc !== 4) begin
      n_fail++;
      $display("FAIL timeout: done_cyc=%0d err=%0b rd_cycles=%0d required 5 / 1 / 4", dc, e, rc);
    end
    n_checks++;
    if (o !== 64'hDEAD_BEEF_8765_4321) begin
      n_fail++;
      $display("FAIL timeout_out_hold: got %016h required DEADBEEF87654321", o);
    end
  endtask

  task automatic test_illegal();
    int dc, rc;
    logic e;
    logic [63:0] o;
    run_load(mk_inst(3'b111, 7'b0000011), 1, 64'h1111_2222_3333_4444, dc, e, o, rc);
    n_checks++;
    if (dc !== 1 || e !== 1'b1 || rc !== 0 || o !== 64'hDEAD_BEEF_8765_4321) begin
      n_fail++;
      $display("FAIL illegal_f3: done_cyc=%0d err=%0b rd=%0d out=%016h required 1 / 1 / 0 / DEADBEEF87654321", dc, e, rc, o);
    end
    run_load(mk_inst(3'b011, 7'b0100011), 1, 64'h1111_2222_3333_4444, dc, e, o, rc);
    n_checks++;
    if (dc !== 1 || e !== 1'b1 || rc !== 0 || o !== 64'hDEAD_BEEF_8765_4321) begin
      n_fail++;
      $display("FAIL illegal_opcode: done_cyc=%0d err=%0b rd=%0d out=%016h required 1 / 1 / 0 / DEADBEEF87654321", dc, e, rc, o);
    end
  endtask

  task automatic test_reset_mid();
    int dc, rc, seen_done;
    logic e;
    logic [63:0] o;
    start = 1'b1;
    Inst  = mk_inst(3'b011, 7'b0000011);
    step();
    start = 1'b0;
    step();             // 2nd BUSY cycle
    reset     = 1'b1;
    mem_valid = 1'b1;
    MemIn     = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    reset     = 1'b0;
    mem_valid = 1'b0;
    MemIn     = 64'h0;
    $display("reset mid-busy flags=%b out=%016h", {mem_rd, busy, done, err}, Out);
    n_checks++;
    if ({mem_rd, busy, done, err} !== 4'b0000 || Out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid: flags=%b Out=%016h required 0000 / 0", {mem_rd, busy, done, err}, Out);
    end
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) seen_done++;
      step();
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: active cycles=%0d required 0", seen_done);
    end
    run_load(mk_inst(3'b000, 7'b0000011), 2, 64'h0000_0000_0000_007F, dc, e, o, rc);
    n_checks++;
    if (o !== 64'h0000_0000_0000_007F || dc !== 3 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lb: out=%016h done_cyc=%0d err=%0b required 000000000000007F / 3 / 0", o, dc, e);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    Inst      = 32'h0;
    mem_valid = 1'b0;
    MemIn     = 64'h0;
    test_reset();
    test_lb();
    test_back_to_back();
    test_word_waits();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
